// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 multiplier round/pack stage.
// Holds the operand class encoding, the exception flag bit positions and the S1 register layout.
package fpu_pkg;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        ZERO = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } class_e;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Exponent is kept outside this struct because its width follows the EXP_W parameter.
    typedef struct packed {
        logic        sign;
        class_e      cls;
        logic [22:0] sig;
        logic        guard;
        logic        sticky;
    } s1_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even increment of a 23-bit fraction.
// Latency: combinational. Backpressure: none (pure function of inputs).
module fpu_round_rne (
    input  logic [22:0] sig,
    input  logic        guard,
    input  logic        sticky,
    output logic [22:0] sig_rnd,
    output logic        carry,
    output logic        inexact
);

    logic        w_inc;
    logic [23:0] w_sum;

    // Ties go up only when the kept LSB is odd.
    assign w_inc   = guard & (sticky | sig[0]);
    assign w_sum   = {1'b0, sig} + {23'd0, w_inc};
    assign sig_rnd = w_sum[22:0];
    assign carry   = w_sum[23];
    assign inexact = guard | sticky;

endmodule

// File: rtl/fpu_mul_round_pack.sv
// FP32 multiplier back end: normalise (S1), round-to-nearest-even, range check and pack (S2).
// Latency 2 cycles, full throughput; in_ready drops only when both stages hold data and out_ready=0.
// Optional sticky flag accumulator (flags_clr/flags_acc) built when FPU_MUL_FLAG_ACCUM_EN is defined.
module fpu_mul_round_pack
    import fpu_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FPU_MUL_FLAG_ACCUM_EN
    input  logic             flags_clr,
    output logic [4:0]       flags_acc,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_flags
);

    localparam logic signed [EXP_W:0] W_EXP_MAX = (EXP_W+1)'(EXP_MAX);
    localparam logic signed [EXP_W:0] W_ZERO    = '0;
    localparam logic signed [EXP_W:0] W_ONE     = (EXP_W+1)'(1);

    logic                r_s1_vld;
    s1_t                 r_s1;
    logic signed [EXP_W:0] r_s1_exp;
    logic                r_s2_vld;
    logic [31:0]         r_result;
    logic [4:0]          r_flags;

    logic                w_s1_en;
    logic                w_s2_en;
    logic signed [EXP_W:0] w_exp_ext;
    logic signed [EXP_W:0] w_s1_exp_d;
    s1_t                 w_s1_d;
    logic [22:0]         w_sig_rnd;
    logic                w_carry;
    logic                w_inexact;
    logic signed [EXP_W:0] w_carry_ext;
    logic signed [EXP_W:0] w_e_rnd;
    logic [31:0]         w_res;
    logic [4:0]          w_flg;

    assign w_s2_en  = ~r_s2_vld | out_ready;
    assign w_s1_en  = ~r_s1_vld | w_s2_en;
    assign in_ready = w_s1_en;

    // S1: leading one sits at bit 47 or 46; a bit-47 product carries one extra exponent step.
    assign w_exp_ext  = $signed({in_exp[EXP_W-1], in_exp});
    assign w_s1_exp_d = in_mant[47] ? (w_exp_ext + W_ONE) : w_exp_ext;

    always_comb begin
        w_s1_d        = '0;
        w_s1_d.sign   = in_sign;
        w_s1_d.cls    = class_e'(in_class);
        if (in_mant[47]) begin
            w_s1_d.sig    = in_mant[46:24];
            w_s1_d.guard  = in_mant[23];
            w_s1_d.sticky = |in_mant[22:0];
        end else begin
            w_s1_d.sig    = in_mant[45:23];
            w_s1_d.guard  = in_mant[22];
            w_s1_d.sticky = |in_mant[21:0];
        end
    end

    fpu_round_rne u_round (
        .sig     (r_s1.sig),
        .guard   (r_s1.guard),
        .sticky  (r_s1.sticky),
        .sig_rnd (w_sig_rnd),
        .carry   (w_carry),
        .inexact (w_inexact)
    );

    // One spare exponent bit guarantees the +1/+1 steps never wrap.
    assign w_carry_ext = $signed({{EXP_W{1'b0}}, w_carry});
    assign w_e_rnd     = r_s1_exp + w_carry_ext;

    always_comb begin
        w_res = '0;
        w_flg = '0;
        case (r_s1.cls)
            NORM: begin
                if (w_e_rnd >= W_EXP_MAX) begin
                    w_res         = {r_s1.sign, 8'hFF, 23'd0};
                    w_flg[FLG_OF] = 1'b1;
                    w_flg[FLG_NX] = 1'b1;
                end else if (w_e_rnd <= W_ZERO) begin
                    w_res         = {r_s1.sign, 31'd0};
                    w_flg[FLG_UF] = 1'b1;
                    w_flg[FLG_NX] = 1'b1;
                end else begin
                    w_res         = {r_s1.sign, w_e_rnd[7:0], w_sig_rnd};
                    w_flg[FLG_NX] = w_inexact;
                end
            end
            ZERO: w_res = {r_s1.sign, 31'd0};
            INF:  w_res = {r_s1.sign, 8'hFF, 23'd0};
            NAN: begin
                w_res         = QNAN;
                w_flg[FLG_NV] = 1'b1;
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
            r_s1_exp <= '0;
            r_s2_vld <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_vld <= in_valid;
                if (in_valid) begin
                    r_s1     <= w_s1_d;
                    r_s1_exp <= w_s1_exp_d;
                end
            end
            if (w_s2_en) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_result <= w_res;
                    r_flags  <= w_flg;
                end
            end
        end
    end

    assign out_valid  = r_s2_vld;
    assign out_result = r_result;
    assign out_flags  = r_flags;

`ifdef FPU_MUL_FLAG_ACCUM_EN
    logic [4:0] r_flags_acc;
    logic       w_out_hs;

    assign w_out_hs = r_s2_vld & out_ready;

    // Clear wins over history but not over the flags handed off in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_acc <= '0;
        end else if (flags_clr) begin
            r_flags_acc <= w_out_hs ? r_flags : 5'd0;
        end else if (w_out_hs) begin
            r_flags_acc <= r_flags_acc | r_flags;
        end
    end

    assign flags_acc = r_flags_acc;
`endif

endmodule

// File: tb/tb_fpu_mul_round_pack.sv
// Directed-vector bench for fpu_mul_round_pack: table of products with hand-computed results,
// plus backpressure, mid-stream reset and (when FPU_MUL_FLAG_ACCUM_EN is defined) accumulator sequences.
module tb_fpu_mul_round_pack;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic [1:0]  cls;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic [1:0]  in_class;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        flags_clr;
`ifdef FPU_MUL_FLAG_ACCUM_EN
    logic [4:0]  flags_acc;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vt[16];

    always #5 clk = ~clk;

    fpu_mul_round_pack #(.EXP_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FPU_MUL_FLAG_ACCUM_EN
        .flags_clr  (flags_clr),
        .flags_acc  (flags_acc),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_class = v.cls;
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit clr);
        int lat;
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, lat, 32'd2);
        chk({nm, "_result"}, out_result, v.res);
        chk({nm, "_flags"}, {27'd0, out_flags}, {27'd0, v.flg});
        flags_clr = clr;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int oidx;
        bit acc;

        //        sign  exp      mant                 cls    result          flags
        vt[0]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 2'd0, 32'h4010_0000, 5'b00000};
        vt[1]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 2'd0, 32'h3F80_0000, 5'b00001};
        vt[2]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 2'd0, 32'h3F80_0002, 5'b00001};
        vt[3]  = '{1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 2'd0, 32'h7F80_0000, 5'b00101};
        vt[4]  = '{1'b1, 10'd0,   48'h4000_0000_0000, 2'd0, 32'h8000_0000, 5'b00011};
        vt[5]  = '{1'b1, 10'd0,   48'h4000_0000_0000, 2'd3, 32'h7FC0_0000, 5'b10000};
        vt[6]  = '{1'b1, 10'd5,   48'h0000_0000_0000, 2'd1, 32'h8000_0000, 5'b00000};
        vt[7]  = '{1'b0, 10'd5,   48'h0000_0000_0000, 2'd2, 32'h7F80_0000, 5'b00000};
        vt[8]  = '{1'b0, 10'd253, 48'h8000_0000_0000, 2'd0, 32'h7F00_0000, 5'b00000};
        vt[9]  = '{1'b0, 10'd0,   48'h8000_0000_0000, 2'd0, 32'h0080_0000, 5'b00000};
        vt[10] = '{1'b0, 10'd255, 48'h4000_0000_0000, 2'd0, 32'h7F80_0000, 5'b00101};
        vt[11] = '{1'b0, 10'h338, 48'h4000_0000_0000, 2'd0, 32'h0000_0000, 5'b00011};
        vt[12] = '{1'b0, 10'h1FF, 48'h8000_0000_0000, 2'd0, 32'h7F80_0000, 5'b00101};
        vt[13] = '{1'b1, 10'd130, 48'h4000_0060_0001, 2'd0, 32'hC100_0001, 5'b00001};
        vt[14] = '{1'b0, 10'd127, 48'h4000_0020_0000, 2'd0, 32'h3F80_0000, 5'b00001};
        vt[15] = '{1'b0, 10'd0,   48'h7FFF_FFFF_FFFF, 2'd0, 32'h0080_0000, 5'b00001};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        drive(vt[0]);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_flags", {27'd0, out_flags}, 32'd0);
`ifdef FPU_MUL_FLAG_ACCUM_EN
        chk("reset_flags_acc", {27'd0, flags_acc}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Backpressure: four products, out_ready low for the first three cycles.
        idx  = 0;
        oidx = 0;
        for (int c = 0; c < 40 && oidx < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            if (idx < 4) begin
                drive(vt[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_accepts_before_stall", idx, 32'd2);
                chk("bp_held_payload", out_result, vt[0].res);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", oidx), out_result, vt[oidx].res);
                oidx++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        chk("bp_out_count", oidx, 32'd4);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Mid-stream reset: fill both stages, then pull rst_n away from a clock edge.
        @(negedge clk);
        out_ready = 1'b0;
        drive(vt[2]);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pre_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_out_result", out_result, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_post_out_valid", {31'd0, out_valid}, 32'd0);
        run_vec(vt[13], "post_reset", 1'b0);

`ifdef FPU_MUL_FLAG_ACCUM_EN
        // Accumulator: gather, clear alone, then clear together with a handshake.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("acc_after_reset", {27'd0, flags_acc}, 32'd0);
        run_vec(vt[1], "acc_nx", 1'b0);
        chk("acc_nx_val", {27'd0, flags_acc}, 32'h01);
        run_vec(vt[3], "acc_of", 1'b0);
        chk("acc_of_val", {27'd0, flags_acc}, 32'h05);
        run_vec(vt[5], "acc_nv", 1'b0);
        chk("acc_nv_val", {27'd0, flags_acc}, 32'h15);
        @(negedge clk);
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        chk("acc_clr_alone", {27'd0, flags_acc}, 32'h00);
        run_vec(vt[3], "acc_of2", 1'b0);
        chk("acc_of2_val", {27'd0, flags_acc}, 32'h05);
        run_vec(vt[4], "acc_clr_hs", 1'b1);
        chk("acc_clr_hs_val", {27'd0, flags_acc}, 32'h03);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
